// File: rtl/svga_timing_gen.sv
// svga_timing_gen
// Pixel-clock timing generator for an 800x600@60 Hz SVGA output path.
// Produces registered h/v sync, blanking, display enable, raw pixel
// coordinates and line/frame start strobes, all decoded from one position
// so they stay mutually aligned.
//
// Ports:
//   clk_svga    in   pixel clock, rising edge
//   rst         in   synchronous active-high reset
//   ce          in   clock enable; position advances only when ce=1
//   hsync       out  horizontal sync, active level HSYNC_POL
//   vsync       out  vertical sync, active level VSYNC_POL
//   hblank      out  1 when x >= H_ACTIVE
//   vblank      out  1 when y >= V_ACTIVE
//   de          out  display enable (~hblank & ~vblank)
//   x           out  horizontal position 0..H_TOTAL-1 (not clamped)
//   y           out  vertical position 0..V_TOTAL-1 (not clamped)
//   line_start  out  one-clock strobe when x = 0
//   frame_start out  one-clock strobe when x = 0 and y = 0
module svga_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        clk_svga,
    input  logic        rst,
    input  logic        ce,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST_C     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BLANK_C    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG_C = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END_C = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST_C     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_BLANK_C    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END_C = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Position to be presented on the next enabled edge.
    logic [10:0] h_next_q, h_next_d;
    logic [9:0]  v_next_q, v_next_d;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblank_q, hblank_d;
    logic        vblank_q, vblank_d;
    logic        de_q, de_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    // Decode of the pending position; registered on the enabled edge.
    logic h_blank_dec, v_blank_dec, h_sync_dec, v_sync_dec;
    logic h_wrap, v_wrap;

    assign h_blank_dec = (h_next_q >= H_BLANK_C);
    assign v_blank_dec = (v_next_q >= V_BLANK_C);
    assign h_sync_dec  = (h_next_q >= H_SYNC_BEG_C) && (h_next_q <= H_SYNC_END_C);
    assign v_sync_dec  = (v_next_q >= V_SYNC_BEG_C) && (v_next_q <= V_SYNC_END_C);
    assign h_wrap      = (h_next_q == H_LAST_C);
    assign v_wrap      = (v_next_q == V_LAST_C);

    always_comb begin
        h_next_d      = h_next_q;
        v_next_d      = v_next_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        // Strobes drop on every non-enabled edge so they last one clock
        // regardless of the ce duty cycle.
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (ce) begin
            x_d           = h_next_q;
            y_d           = v_next_q;
            hblank_d      = h_blank_dec;
            vblank_d      = v_blank_dec;
            de_d          = ~h_blank_dec & ~v_blank_dec;
            hsync_d       = h_sync_dec ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = v_sync_dec ? VSYNC_POL : ~VSYNC_POL;
            line_start_d  = (h_next_q == 11'd0);
            frame_start_d = (h_next_q == 11'd0) && (v_next_q == 10'd0);

            if (h_wrap) begin
                h_next_d = 11'd0;
                v_next_d = v_wrap ? 10'd0 : v_next_q + 10'd1;
            end else begin
                h_next_d = h_next_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk_svga) begin
        if (rst) begin
            h_next_q      <= 11'd0;
            v_next_q      <= 10'd0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            de_q          <= 1'b0;
            x_q           <= 11'd0;
            y_q           <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_next_q      <= h_next_d;
            v_next_q      <= v_next_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
